bsram_byte_ctrl: RTL and testbench
==================================

Name: bsram_byte_ctrl

Overview:
- Requester-side controller for the 16 KiB single-port block RAM (ce/wre/14-bit addr/8-bit din/dout).
- Sits between the I2C target's byte stream and the RAM.
- Converts a two-byte address preamble plus data bytes into RAM write cycles with an auto-incrementing pointer.
- Issues pointer-addressed RAM reads on request and returns data after the RAM's read latency.

Parameters:
ADDR_W, 14, RAM address width; pointer wraps modulo 2^ADDR_W
DATA_W, 8, byte width
RD_LAT, 1, RAM read latency in cycles from the ce edge to valid dout; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; a new I2C transaction is addressed to this target
wr_valid  input  1  byte from the I2C target is present on wr_data
wr_data  input  DATA_W  byte from the I2C target
wr_ready  output  1  byte accepted on the edge where wr_valid && wr_ready
rd_req  input  1  request the next byte for the I2C target; held until accepted
rd_ready  output  1  rd_req accepted on the edge where rd_req && rd_ready
rd_valid  output  1  one-cycle pulse; rd_data is valid
rd_data  output  DATA_W  read byte; holds its value until the next rd_valid
ptr  output  ADDR_W  current address pointer (status/debug)
mem_ce  output  1  RAM clock enable (registered)
mem_wre  output  1  RAM write enable (registered)
mem_addr  output  ADDR_W  RAM address (registered)
mem_din  output  DATA_W  RAM write data (registered)
mem_dout  input  DATA_W  RAM read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, mem_ce=0, mem_wre=0, mem_addr=0, mem_din=0, rd_valid=0, rd_data=0, read-pending counter=0. Outputs are reset values while rst_n=0.
- States:
  - IDLE: bytes are accepted and discarded.
  - ADDR_HI: an accepted byte sets ptr[13:8]=wr_data[5:0]; wr_data[7:6] are ignored. ptr[7:0] is unchanged. Next state ADDR_LO.
  - ADDR_LO: an accepted byte sets ptr[7:0]=wr_data. Next state DATA.
  - DATA: an accepted byte is written at ptr, then ptr=ptr+1. State is unchanged.
- start pulse: go to ADDR_HI from any state. wr_ready=0 in the start cycle, so a coincident byte is not accepted.
- Write issue: byte accepted at edge N → in cycle N+1, mem_ce=1, mem_wre=1, mem_addr=old ptr, mem_din=byte. All are deasserted/returned next cycle unless another access is issued.
- Read issue: rd_req accepted at edge N →
  - cycle N+1: mem_ce=1, mem_wre=0, mem_addr=old ptr; ptr increments at edge N.
  - cycle N+1+RD_LAT: rd_valid=1 and rd_data=mem_dout, captured into a hold register.
- Reads are legal in every state and never change state. Write-address-then-repeated-start-read works because start only re-arms the address preamble.
- Pointer: increments modulo 2^ADDR_W; 0x3FFF+1 = 0x0000. Address bytes do not increment it.
- Ready rules:
  - rd_ready = !read_pending && !start && !(wr_valid && state!=IDLE).
  - wr_ready = !read_pending && !start.
  - read_pending covers cycles N+1 through N+1+RD_LAT.
  - When a write and a read are both presented, the write wins and rd_req waits.
  - At most one RAM access is issued per cycle; back-to-back writes issue every cycle.
- start during an outstanding read: the read completes and rd_valid still fires; state goes to ADDR_HI.
- rd_data is never updated except on rd_valid.

Test Plan:
- Reset then idle → all outputs 0, wr_ready=1, rd_ready=1; bytes 0x55 in IDLE accepted with no mem_ce.
- start; bytes 0x01,0x23,0xAA,0xBB → writes 0xAA@0x0123 and 0xBB@0x0124 on consecutive cycles; ptr=0x0125.
- start; bytes 0xFF,0xFF,0x11,0x22 → ptr loads 0x3FFF (bits 7:6 ignored); writes 0x11@0x3FFF then 0x22@0x0000; ptr=0x0001.
- After the first case: start; 0x01,0x23; start; two rd_req with RD_LAT=1 → rd_valid 2 cycles after each accept with 0xAA then 0xBB; rd_ready low between; ptr=0x0125. Repeat with RD_LAT=2: 3 cycles.
- wr_valid and rd_req asserted together in DATA → write issued first, read accepted next cycle; no cycle has two accesses.
- rst_n low during a pending read → rd_valid never fires, ptr=0; start coincident with a byte → byte not accepted, state ADDR_HI.

Source files
------------

// File: rtl/bsram_byte_ctrl.sv
// Byte-stream controller in front of a single-port block RAM: a two-byte address
// preamble loads the pointer, following bytes are written at an auto-incrementing pointer.
// Latency: writes reach the RAM port one cycle after acceptance; read data returns RD_LAT+1 cycles after rd_req is accepted.
// Backpressure: wr_ready/rd_ready drop while a read is in flight and during start; a presented write beats a read.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start                    new transaction pulse, re-arms the address preamble
//   wr_valid/wr_data/wr_ready incoming byte stream (address bytes then data bytes)
//   rd_req/rd_ready          read request handshake (reads at ptr, then ptr++)
//   rd_valid/rd_data         returned read byte; rd_data holds between pulses
//   ptr                      current address pointer
//   mem_ce/mem_wre/mem_addr/mem_din/mem_dout  registered RAM port
module bsram_byte_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ptr,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA
  } state_t;

  state_t            state;
  logic [1:0]        rd_cnt;   // counts down through the cycles a read occupies the RAM path
  logic [DATA_W-1:0] rd_hold;
  logic              rd_pend;
  logic              wr_acc;
  logic              rd_acc;

  assign rd_pend  = (rd_cnt != 2'd0);
  assign wr_ready = !rd_pend && !start;
  // A byte in IDLE is discarded and never touches the RAM, so it does not block a read.
  assign rd_ready = !rd_pend && !start && !(wr_valid && (state != S_IDLE));
  assign wr_acc   = wr_valid && wr_ready;
  assign rd_acc   = rd_req && rd_ready;

  // The RAM output is only valid in the rd_valid cycle, so pass it straight through
  // then and present the captured copy afterwards.
  assign rd_data  = rd_valid ? mem_dout : rd_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      mem_ce   <= 1'b0;
      mem_wre  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_valid <= 1'b0;
      rd_hold  <= '0;
      rd_cnt   <= 2'd0;
    end else begin
      mem_ce  <= 1'b0;
      mem_wre <= 1'b0;

      if (start) begin
        state <= S_ADDR_HI;
      end else if (wr_acc) begin
        case (state)
          S_ADDR_HI: begin
            ptr[ADDR_W-1:8] <= wr_data[HI_W-1:0];
            state           <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            ptr[7:0] <= wr_data[7:0];
            state    <= S_DATA;
          end
          S_DATA: begin
            mem_ce   <= 1'b1;
            mem_wre  <= 1'b1;
            mem_addr <= ptr;
            mem_din  <= wr_data;
            ptr      <= ptr + 1'b1;
          end
          default: ;
        endcase
      end

      // rd_ready excludes a concurrent DATA-state write, so this never collides
      // with the write issue above.
      if (rd_acc) begin
        mem_ce   <= 1'b1;
        mem_wre  <= 1'b0;
        mem_addr <= ptr;
        ptr      <= ptr + 1'b1;
      end

      if (rd_acc)
        rd_cnt <= 2'(RD_LAT + 1);
      else if (rd_pend)
        rd_cnt <= rd_cnt - 2'd1;

      rd_valid <= (rd_cnt == 2'd2);
      if (rd_valid)
        rd_hold <= mem_dout;
    end
  end

endmodule

// File: tb/tb_bsram_byte_ctrl.sv
// Bench for bsram_byte_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share the byte stream,
// each with its own RAM model; writes and read returns are checked against queued expectations.
// Runs a fixed stimulus table plus hand-written corner sequences, then prints one summary line.
module tb_bsram_byte_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic rd_req_a = 1'b0;
  logic rd_req_b = 1'b0;

  logic wr_ready_a, rd_ready_a, rd_valid_a, mem_ce_a, mem_wre_a;
  logic [7:0] rd_data_a, mem_din_a, mem_dout_a;
  logic [13:0] ptr_a, mem_addr_a;
  logic wr_ready_b, rd_ready_b, rd_valid_b, mem_ce_b, mem_wre_b;
  logic [7:0] rd_data_b, mem_din_b, mem_dout_b;
  logic [13:0] ptr_b, mem_addr_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsram_byte_ctrl #(.ADDR_W(14), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_a),
    .rd_req(rd_req_a), .rd_ready(rd_ready_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
    .ptr(ptr_a), .mem_ce(mem_ce_a), .mem_wre(mem_wre_a), .mem_addr(mem_addr_a),
    .mem_din(mem_din_a), .mem_dout(mem_dout_a)
  );

  bsram_byte_ctrl #(.ADDR_W(14), .DATA_W(8), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_b),
    .rd_req(rd_req_b), .rd_ready(rd_ready_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .ptr(ptr_b), .mem_ce(mem_ce_b), .mem_wre(mem_wre_b), .mem_addr(mem_addr_b),
    .mem_din(mem_din_b), .mem_dout(mem_dout_b)
  );

  // RAM models: one output register stage for A, two for B.
  logic [7:0] ram_a [16384];
  logic [7:0] ram_b [16384];
  logic [7:0] s1_a = 8'h00, s1_b = 8'h00, s2_b = 8'h00;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram_a[i] = 8'h00;
      ram_b[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_ce_a) begin
      if (mem_wre_a) ram_a[mem_addr_a] <= mem_din_a;
      else           s1_a <= ram_a[mem_addr_a];
    end
    if (mem_ce_b) begin
      if (mem_wre_b) ram_b[mem_addr_b] <= mem_din_b;
      else           s1_b <= ram_b[mem_addr_b];
    end
    s2_b <= s1_b;
  end

  assign mem_dout_a = s1_a;
  assign mem_dout_b = s2_b;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  din;
    int          cyc;
  } wr_item_t;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } rd_item_t;

  wr_item_t wq[$];
  rd_item_t rq_a[$];
  rd_item_t rq_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: compare RAM writes (instance A) and read returns (both) as they appear.
  always @(negedge clk) begin
    wr_item_t w;
    rd_item_t r;
    if (mem_ce_a && mem_wre_a) begin
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(mem_addr_a), 32'(w.addr));
        chk("wr_din", 32'(mem_din_a), 32'(w.din));
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (rd_valid_a) begin
      if (rq_a.size() == 0) flag("unexpected_rd_valid_a");
      else begin
        r = rq_a.pop_front();
        chk("rd_data_a", 32'(rd_data_a), 32'(r.d));
        chk("rd_cycle_a", cyc, r.cyc);
      end
    end
    if (rd_valid_b) begin
      if (rq_b.size() == 0) flag("unexpected_rd_valid_b");
      else begin
        r = rq_b.pop_front();
        chk("rd_data_b", 32'(rd_data_b), 32'(r.d));
        chk("rd_cycle_b", cyc, r.cyc);
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    wr_valid = 1'b1;
    wr_data  = b;
    n = 0;
    @(negedge clk);
    while (!(wr_ready_a && wr_ready_b) && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("wr_ready_timeout", 0, 1);
    acc = cyc;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Two back-to-back reads held on rd_req; expects 0xAA then 0xBB.
  task automatic read_two(input bit sel, input int lat);
    int acc [2];
    logic [7:0] exp_d [2];
    int n;
    exp_d[0] = 8'hAA;
    exp_d[1] = 8'hBB;
    if (sel) rd_req_b = 1'b1; else rd_req_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      @(negedge clk);
      while (!(sel ? rd_ready_b : rd_ready_a) && n < 20) begin
        n++;
        @(negedge clk);
      end
      if (n >= 20) chk("rd_ready_timeout", 0, 1);
      acc[i] = cyc;
      if (sel) rq_b.push_back('{exp_d[i], cyc + 1 + lat});
      else     rq_a.push_back('{exp_d[i], cyc + 1 + lat});
      @(posedge clk); #1;
    end
    rd_req_a = 1'b0;
    rd_req_b = 1'b0;
    chk(sel ? "rd_gap_b" : "rd_gap_a", acc[1] - acc[0], lat + 2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq_a.size() != 0 || rq_b.size() != 0 || wq.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", rq_a.size() + rq_b.size() + wq.size(), 0);
  endtask

  typedef struct {
    bit          st;
    logic [7:0]  b;
    logic [13:0] ptr;
    bit          wr;
    logic [13:0] addr;
  } step_t;

  step_t tbl [11];

  task automatic run_table(input int lo, input int hi);
    int acc;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].st) pulse_start();
      send_byte(tbl[i].b, acc);
      if (tbl[i].wr) wq.push_back('{tbl[i].addr, tbl[i].b, acc + 1});
      chk($sformatf("ptr_a_step%0d", i), 32'(ptr_a), 32'(tbl[i].ptr));
      chk($sformatf("ptr_b_step%0d", i), 32'(ptr_b), 32'(tbl[i].ptr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;

    tbl = '{
      '{1'b0, 8'h55, 14'h0000, 1'b0, 14'h0000},   // IDLE: discarded
      '{1'b1, 8'h01, 14'h0100, 1'b0, 14'h0000},
      '{1'b0, 8'h23, 14'h0123, 1'b0, 14'h0000},
      '{1'b0, 8'hAA, 14'h0124, 1'b1, 14'h0123},
      '{1'b0, 8'hBB, 14'h0125, 1'b1, 14'h0124},
      '{1'b1, 8'hFF, 14'h3F25, 1'b0, 14'h0000},   // bits 7:6 of high byte ignored
      '{1'b0, 8'hFF, 14'h3FFF, 1'b0, 14'h0000},
      '{1'b0, 8'h11, 14'h0000, 1'b1, 14'h3FFF},   // wrap
      '{1'b0, 8'h22, 14'h0001, 1'b1, 14'h0000},
      '{1'b1, 8'h01, 14'h0101, 1'b0, 14'h0000},   // re-address for reads
      '{1'b0, 8'h23, 14'h0123, 1'b0, 14'h0000}
    };

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ptr", 32'(ptr_a), 0);
    chk("rst_mem_ce", 32'(mem_ce_a), 0);
    chk("rst_mem_addr", 32'(mem_addr_a), 0);
    chk("rst_mem_din", 32'(mem_din_a), 0);
    chk("rst_rd_valid", 32'(rd_valid_a), 0);
    chk("rst_rd_data", 32'(rd_data_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wr_ready", 32'(wr_ready_a), 1);
    chk("idle_rd_ready", 32'(rd_ready_a), 1);
    @(posedge clk); #1;

    // Byte stream: IDLE discard, preamble, writes, wrap.
    run_table(0, 10);
    drain();

    // Repeated start then reads, RD_LAT=1 then RD_LAT=2.
    pulse_start();
    read_two(1'b0, 1);
    drain();
    chk("ptr_a_after_reads", 32'(ptr_a), 32'h0125);
    read_two(1'b1, 2);
    drain();
    chk("ptr_b_after_reads", 32'(ptr_b), 32'h0125);

    // Write and read presented together in DATA: write first, read next cycle.
    pulse_start();
    send_byte(8'h02, acc);
    send_byte(8'h00, acc);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    rd_req_a = 1'b1;
    @(negedge clk);
    chk("collide_wr_ready", 32'(wr_ready_a), 1);
    chk("collide_rd_ready", 32'(rd_ready_a), 0);
    wq.push_back('{14'h0200, 8'h77, cyc + 1});
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("collide_rd_ready_next", 32'(rd_ready_a), 1);
    rq_a.push_back('{8'h00, cyc + 2});
    @(posedge clk); #1;
    rd_req_a = 1'b0;
    drain();
    chk("collide_ptr", 32'(ptr_a), 32'h0202);

    // Reset while a read is pending: no rd_valid may follow.
    rd_req_a = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rd_ready_a && n < 20) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rd_req_a = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ptr_a", 32'(ptr_a), 0);
    chk("arst_ptr_b", 32'(ptr_b), 0);
    chk("arst_mem_ce", 32'(mem_ce_a), 0);
    chk("arst_rd_data_b", 32'(rd_data_b), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // start coincident with a byte: byte refused, preamble re-armed.
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h3F;
    @(negedge clk);
    chk("start_wr_ready", 32'(wr_ready_a), 0);
    chk("start_rd_ready", 32'(rd_ready_a), 0);
    @(posedge clk); #1;
    start    = 1'b0;
    wr_valid = 1'b0;
    send_byte(8'h12, acc);
    chk("start_hi_ptr", 32'(ptr_a), 32'h1200);
    send_byte(8'h34, acc);
    chk("start_lo_ptr", 32'(ptr_a), 32'h1234);
    send_byte(8'h99, acc);
    wq.push_back('{14'h1234, 8'h99, acc + 1});
    drain();
    chk("final_ptr", 32'(ptr_a), 32'h1235);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
